// File: rtl/traffic_light_monitor_if.sv
// Light buses between the traffic light controller (master) and the
// safety monitor (slave). Each bus is one-hot {R,Y,G}.
interface traffic_light_monitor_if;
  logic [2:0] light_M1;
  logic [2:0] light_S;
  logic [2:0] light_MT;
  logic [2:0] light_M2;

  modport master (output light_M1, light_S, light_MT, light_M2);
  modport slave  (input  light_M1, light_S, light_MT, light_M2);
endinterface

// File: rtl/traffic_light_monitor.sv
// Safety monitor for the traffic light controller: checks encoding,
// right-of-way conflicts, colour sequence, dwell times and a stuck
// watchdog, and latches the first violation as a sticky fault report.

// Per-road checker: remembers the last legal colour and how long the
// bus has shown it, and flags sequence and minimum-dwell violations.
module tlm_road #(
  parameter int GRN_MIN = 2,
  parameter int YEL_MIN = 3,
  parameter int CNT_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] cur,
  output logic       legal,
  output logic       changed,
  output logic       seq_err,
  output logic       min_err
);
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;
  localparam logic [CNT_W-1:0] GRN_LIM = CNT_W'(GRN_MIN);
  localparam logic [CNT_W-1:0] YEL_LIM = CNT_W'(YEL_MIN);
  localparam logic [CNT_W-1:0] SAT     = '1;

  logic [2:0]       prev;
  logic [CNT_W-1:0] dwell;

  assign legal   = (cur == R) || (cur == Y) || (cur == G);
  assign changed = (cur != prev);
  assign seq_err = legal && changed &&
                   !((prev == R && cur == G) || (prev == G && cur == Y) ||
                     (prev == Y && cur == R));
  assign min_err = legal &&
                   ((prev == G && cur == Y && dwell < GRN_LIM) ||
                    (prev == Y && cur == R && dwell < YEL_LIM));

  // Track last legal colour (illegal samples are ignored) and its dwell.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev  <= R;
      dwell <= '0;
    end else begin
      if (legal) prev <= cur;
      if (changed)           dwell <= CNT_W'(1);
      else if (dwell != SAT) dwell <= dwell + 1'b1;
    end
  end
endmodule

module traffic_light_monitor #(
  parameter int GRN_MIN = 2,
  parameter int YEL_MIN = 3,
  parameter int WDT     = 60,
  parameter int CNT_W   = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  traffic_light_monitor_if.slave         bus,
  input  logic                           clr,
  output logic                           fault,
  output logic [2:0]                     fault_code,
  output logic [1:0]                     fault_road,
  output logic                           flash_req
);
  localparam logic [2:0]       R       = 3'b100;
  localparam logic [CNT_W-1:0] WDT_LIM = CNT_W'(WDT - 1);
  localparam logic [CNT_W-1:0] SAT     = '1;

  // Road index: M1=0, S=1, MT=2, M2=3.
  logic [3:0][2:0]  cur;
  logic [3:0]       legal, changed, seq_err, min_err, nr;
  logic [CNT_W-1:0] wdt_cnt;
  logic             wdt_hit;
  logic             c_m1_s, c_s_any, c_mt_m2;
  logic [2:0]       det_code;
  logic [1:0]       det_road;

  assign cur = {bus.light_M2, bus.light_MT, bus.light_S, bus.light_M1};

  tlm_road #(.GRN_MIN(GRN_MIN), .YEL_MIN(YEL_MIN), .CNT_W(CNT_W)) u_road [3:0] (
    .clk     (clk),
    .rst     (rst),
    .cur     (cur),
    .legal   (legal),
    .changed (changed),
    .seq_err (seq_err),
    .min_err (min_err)
  );

  always_comb begin
    for (int i = 0; i < 4; i++) nr[i] = (cur[i] != R);
  end

  // Conflicting pairs; M1 with M2 or MT is a permitted combination.
  assign c_m1_s  = nr[1] && nr[0];
  assign c_s_any = nr[1] && (nr[2] || nr[3]);
  assign c_mt_m2 = nr[2] && nr[3];
  assign wdt_hit = !(|changed) && (wdt_cnt == WDT_LIM);

  // Watchdog: counts samples with no change on any bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                wdt_cnt <= '0;
    else if (|changed)       wdt_cnt <= '0;
    else if (wdt_cnt != SAT) wdt_cnt <= wdt_cnt + 1'b1;
  end

  // Priority resolve: lower code first, then lowest road index.
  always_comb begin
    det_code = 3'd0;
    det_road = 2'd0;
    if (!(&legal)) begin
      det_code = 3'd1;
      for (int i = 3; i >= 0; i--) if (!legal[i]) det_road = 2'(i);
    end else if (c_m1_s || c_s_any || c_mt_m2) begin
      det_code = 3'd2;
      det_road = c_m1_s ? 2'd0 : (c_s_any ? 2'd1 : 2'd2);
    end else if (|seq_err) begin
      det_code = 3'd3;
      for (int i = 3; i >= 0; i--) if (seq_err[i]) det_road = 2'(i);
    end else if (|min_err) begin
      det_code = 3'd4;
      for (int i = 3; i >= 0; i--) if (min_err[i]) det_road = 2'(i);
    end else if (wdt_hit) begin
      det_code = 3'd5;
    end
  end

  // Sticky first-fault report; a fresh detection beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault      <= 1'b0;
      fault_code <= 3'd0;
      fault_road <= 2'd0;
      flash_req  <= 1'b0;
    end else begin
      flash_req <= fault;
      if (det_code != 3'd0 && (!fault || clr)) begin
        fault      <= 1'b1;
        fault_code <= det_code;
        fault_road <= det_road;
      end else if (clr) begin
        fault      <= 1'b0;
        fault_code <= 3'd0;
        fault_road <= 2'd0;
      end
    end
  end
endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: a reference model predicts the fault
// outputs for every driven sample into a queue, compared after the edge.
module tb_traffic_light_monitor;
  localparam int RD = 4, YL = 2, GN = 1;
  localparam int GRN_MIN = 2, YEL_MIN = 3, WDT = 60, SAT = 255;

  typedef struct packed {
    logic       fault;
    logic [2:0] code;
    logic [1:0] road;
    logic       flash;
  } exp_t;

  logic clk, rst, clr;
  logic fault, flash_req;
  logic [2:0] fault_code;
  logic [1:0] fault_road;

  traffic_light_monitor_if tl_if();

  traffic_light_monitor #(.GRN_MIN(GRN_MIN), .YEL_MIN(YEL_MIN), .WDT(WDT), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (tl_if),
    .clr        (clr),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_road (fault_road),
    .flash_req  (flash_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_bad = 0;
  exp_t sb_q[$];

  int m_prev[4], m_dwell[4];
  int m_wdt, m_fault, m_code, m_road, m_flash;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_leg(input int c);
    return (c == RD) || (c == YL) || (c == GN);
  endfunction

  function automatic bit ok_step(input int p, input int c);
    return (p == c) || (p == RD && c == GN) || (p == GN && c == YL) || (p == YL && c == RD);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_prev[i] = RD; m_dwell[i] = 0; end
    m_wdt = 0; m_fault = 0; m_code = 0; m_road = 0; m_flash = 0;
  endtask

  task automatic model_step(input int c[4], input int cl);
    int code, road;
    bit any_chg;
    int pa[4], pb[4];
    exp_t e;
    pa = '{0, 1, 1, 2};
    pb = '{1, 2, 3, 3};
    code = 0; road = 0; any_chg = 0;
    for (int i = 0; i < 4; i++) if (c[i] != m_prev[i]) any_chg = 1;
    for (int i = 0; i < 4; i++)
      if (code == 0 && !is_leg(c[i])) begin code = 1; road = i; end
    for (int k = 0; k < 4; k++)
      if (code == 0 && c[pa[k]] != RD && c[pb[k]] != RD) begin code = 2; road = pa[k]; end
    for (int i = 0; i < 4; i++)
      if (code == 0 && !ok_step(m_prev[i], c[i])) begin code = 3; road = i; end
    for (int i = 0; i < 4; i++)
      if (code == 0 && ((m_prev[i] == GN && c[i] == YL && m_dwell[i] < GRN_MIN) ||
                        (m_prev[i] == YL && c[i] == RD && m_dwell[i] < YEL_MIN))) begin
        code = 4; road = i;
      end
    if (code == 0 && !any_chg && m_wdt == WDT - 1) begin code = 5; road = 0; end

    m_flash = m_fault;
    if (code != 0 && (m_fault == 0 || cl != 0)) begin
      m_fault = 1; m_code = code; m_road = road;
    end else if (cl != 0) begin
      m_fault = 0; m_code = 0; m_road = 0;
    end
    for (int i = 0; i < 4; i++) begin
      if (c[i] != m_prev[i]) m_dwell[i] = 1;
      else if (m_dwell[i] < SAT) m_dwell[i]++;
      if (is_leg(c[i])) m_prev[i] = c[i];
    end
    if (any_chg) m_wdt = 0;
    else if (m_wdt < SAT) m_wdt++;

    e.fault = m_fault[0]; e.code = 3'(m_code); e.road = 2'(m_road); e.flash = m_flash[0];
    sb_q.push_back(e);
  endtask

  task automatic step(input int m1, input int s, input int mt, input int m2, input int cl);
    int c[4];
    exp_t e;
    c = '{m1, s, mt, m2};
    tl_if.light_M1 = 3'(m1);
    tl_if.light_S  = 3'(s);
    tl_if.light_MT = 3'(mt);
    tl_if.light_M2 = 3'(m2);
    clr = cl[0];
    model_step(c, cl);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb_q.pop_front();
      chk("fault", int'(fault), int'(e.fault));
      chk("fault_code", int'(fault_code), int'(e.code));
      chk("fault_road", int'(fault_road), int'(e.road));
      chk("flash_req", int'(flash_req), int'(e.flash));
    end
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_fault", int'(fault), 0);
    chk("rst_code", int'(fault_code), 0);
    chk("rst_road", int'(fault_road), 0);
    chk("rst_flash", int'(flash_req), 0);
    model_reset();
    #2 rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: total=%0d bad=%0d", n_chk, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; clr = 1'b0;
    tl_if.light_M1 = 3'b100; tl_if.light_S = 3'b100;
    tl_if.light_MT = 3'b100; tl_if.light_M2 = 3'b100;
    model_reset();
    #1;
    chk("init_fault", int'(fault), 0);
    chk("init_code", int'(fault_code), 0);
    chk("init_flash", int'(flash_req), 0);
    #6 rst = 1'b1;

    // Legal cycle: main roads, then side road; yellow held exactly YEL_MIN.
    repeat (4) step(GN, RD, RD, GN, 0);
    repeat (3) step(YL, RD, RD, YL, 0);
    step(RD, RD, RD, RD, 0);
    repeat (3) step(RD, GN, RD, RD, 0);
    repeat (3) step(RD, YL, RD, RD, 0);
    repeat (2) step(RD, RD, RD, RD, 0);
    chk("legal_fault", int'(fault), 0);
    chk("legal_flash", int'(flash_req), 0);

    // Illegal encoding on S, then flash follow-up and clear.
    step(RD, 3, RD, RD, 0);
    chk("c1_code", int'(fault_code), 1);
    chk("c1_road", int'(fault_road), 1);
    step(RD, RD, RD, RD, 0);
    chk("c1_flash", int'(flash_req), 1);
    step(RD, RD, RD, RD, 1);
    chk("clr_fault", int'(fault), 0);
    chk("clr_code", int'(fault_code), 0);
    step(RD, RD, RD, RD, 0);

    // Conflicts.
    step(GN, YL, RD, RD, 0);
    chk("c2a_code", int'(fault_code), 2);
    chk("c2a_road", int'(fault_road), 0);
    do_reset();
    step(RD, RD, GN, GN, 0);
    chk("c2b_code", int'(fault_code), 2);
    chk("c2b_road", int'(fault_road), 2);
    do_reset();

    // Short yellow on M2, then a later sequence error must not overwrite.
    repeat (2) step(RD, RD, RD, GN, 0);
    repeat (2) step(RD, RD, RD, YL, 0);
    step(GN, RD, RD, RD, 0);
    chk("c4_code", int'(fault_code), 4);
    chk("c4_road", int'(fault_road), 3);
    step(RD, RD, RD, RD, 0);
    chk("c4_sticky", int'(fault_code), 4);
    do_reset();

    // Watchdog on the 60th unchanged sample.
    repeat (WDT - 1) step(RD, RD, RD, RD, 0);
    chk("wdt_early", int'(fault), 0);
    step(RD, RD, RD, RD, 0);
    chk("c5_code", int'(fault_code), 5);
    chk("c5_road", int'(fault_road), 0);

    // Detection in the same cycle as clear wins.
    repeat (2) step(GN, RD, RD, RD, 0);
    step(YL, RD, RD, RD, 0);
    step(GN, RD, RD, RD, 1);
    chk("c3_fault", int'(fault), 1);
    chk("c3_code", int'(fault_code), 3);

    // Reset while faulted with M1 yellow; R afterwards is clean.
    step(GN, RD, RD, RD, 0);
    step(YL, RD, RD, RD, 0);
    chk("pre_rst_fault", int'(fault), 1);
    do_reset();
    step(RD, RD, RD, RD, 0);
    chk("post_rst_fault", int'(fault), 0);
    step(RD, RD, RD, RD, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Independent safety monitor that sits on the receiving end of the four 3-bit light buses driven by the traffic light controller (`light_M1`, `light_S`, `light_MT`, `light_M2`). It samples the buses every clock and checks four things:
- encoding legality;
- conflicting right-of-way;
- the legal colour sequence;
- minimum dwell times and a stuck-controller watchdog.

The first violation is latched into a sticky fault report that a supervisor reads, or that forces the intersection into flash mode.

## Interface
Parameters:
- `GRN_MIN`, 2: minimum cycles a green must be held before going yellow
- `YEL_MIN`, 3: minimum cycles a yellow must be held before going red
- `WDT`, 60: cycles with no change on any bus before a stuck fault is raised
- `CNT_W`, 8: width of dwell and watchdog counters; counters saturate at 2^CNT_W-1

Ports:
- `clk`  in  1  system clock (1 Hz tick domain, same as controller)
- `rst`  in  1  asynchronous, active-low reset
- `light_M1`  in  3  main road 1 light
- `light_S`  in  3  side road light
- `light_MT`  in  3  main turn lane light
- `light_M2`  in  3  main road 2 light
- `clr`  in  1  synchronous fault clear
- `fault`  out  1  sticky fault flag
- `fault_code`  out  3  code of first latched fault
- `fault_road`  out  2  road index of first latched fault
- `flash_req`  out  1  registered copy of `fault`, for the all-red flash override

## Operation
Light encoding is one-hot, with the bit order {R,Y,G}:
- red = 3'b100
- yellow = 3'b010
- green = 3'b001

Road index used in `fault_road`: M1=0, S=1, MT=2, M2=3.

Per-road state, held in registers:
- previous sample, reset to red;
- dwell counter, reset to 0. It loads 1 when the sample differs from the previous sample, otherwise increments and saturates.

The watchdog counter resets to 0 on any bus change, otherwise increments and saturates.

Checks, evaluated combinationally on the current input against the registered state:
- Code 1, illegal: a bus is not one-hot.
- Code 2, conflict: a non-red `S` together with any other non-red bus, or a non-red `MT` together with a non-red `M2`. The pairs M1+M2 and M1+MT are permitted.
- Code 3, sequence: any transition other than R→G, G→Y, Y→R or hold. So G→R, Y→G and R→Y are errors.
- Code 4, min-time: a G→Y transition with green dwell < `GRN_MIN`, or a Y→R transition with yellow dwell < `YEL_MIN`.
- Code 5, watchdog: the watchdog counter reaches `WDT`-1 while the current sample equals the previous one.

Only legal one-hot samples feed the sequence and min-time checks. An illegal bus is flagged code 1 only, and its previous-sample register keeps its old value.

Multiple simultaneous faults resolve by priority:
- code: 1 > 2 > 3 > 4 > 5;
- road, within a code: lowest index.

For a conflict, `fault_road` is the lowest-index non-red road of the conflicting pair. For watchdog, `fault_road` = 0.

Fault latching:
- `fault_code` and `fault_road` capture only the first fault. While `fault`=1, later faults do not overwrite them.
- `clr`=1 clears `fault`, `fault_code` and `fault_road` to 0 at the next edge.
- If a fault is detected in the same cycle as `clr`, the new fault is latched (detection wins).
- Counters and previous-sample registers are never affected by `clr` or `fault`.

## Timing
- Reset (`rst`=0), asynchronous: `fault`=0, `fault_code`=0, `fault_road`=0, `flash_req`=0, all previous samples = 3'b100, all counters = 0.
- Inputs are sampled at each rising edge. A violation present before edge N sets `fault` after edge N: one-cycle latency from input to `fault`.
- `flash_req` follows `fault` one cycle later: two cycles from input.
- The first sample after reset is compared against all-red. A controller starting in R→G is therefore legal.
- Dwell is counted in samples: a yellow held for exactly `YEL_MIN` samples then going red is legal, and `YEL_MIN`-1 samples is a code 4 fault.
- Saturated counters never wrap. A dwell above 2^CNT_W-1 is still a legal dwell.
- Reset asserted mid-operation immediately clears all state and outputs. No fault is reported for the transition from the last pre-reset sample.

## Test plan
- Legal cycle, with M1 and M2 G for 4 samples, Y for 3, R, then S G for 3, Y for 3, R → `fault` stays 0 for the whole run; `flash_req`=0.
- `light_S`=3'b011 for one sample → `fault`=1 after that edge, `fault_code`=1, `fault_road`=1; `flash_req`=1 one cycle later.
- `light_M1`=G with `light_S`=Y → `fault_code`=2, `fault_road`=0. Then assert `clr` → all fault outputs 0. Then `light_MT`=G with `light_M2`=G → `fault_code`=2, `fault_road`=2.
- `light_M2` R→G→G→Y→Y→R, with yellow held 2 samples and `YEL_MIN`=3 → `fault_code`=4, `fault_road`=3. A following G→R on M1 leaves the code at 4 (sticky first fault).
- All buses held red for 60 cycles after reset → `fault_code`=5, `fault_road`=0 on the 60th unchanged sample. Asserting `clr` in the same cycle that a code 3 fault (M1 Y→G) occurs → `fault`=1, `fault_code`=3.
- Assert `rst`=0 while `fault`=1 and M1 is yellow → outputs clear asynchronously. After release, M1 sampled at R causes no fault.
